// File: rtl/midi_tx_pkg.sv
// Shared MIDI constants and types.
// MIDI_TX_RUNNING_STATUS_EN enables running-status compression.
package midi_tx_pkg;

  localparam int SYSTEM_CLOCK   = 50000000;
  localparam int BYTE_WIDTH     = 8;
  localparam int MIDI_BAUD_RATE = 31250;

  typedef logic [BYTE_WIDTH-1:0] byte_t;

  localparam byte_t MIDI_STATUS_MIN   = 8'h80;
  localparam byte_t MIDI_SYSCOM_MIN   = 8'hF0;
  localparam byte_t MIDI_REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic is_chan_status(byte_t b);
    return (b >= MIDI_STATUS_MIN) && (b < MIDI_SYSCOM_MIN);
  endfunction

  function automatic logic is_syscom(byte_t b);
    return (b >= MIDI_SYSCOM_MIN) && (b < MIDI_REALTIME_MIN);
  endfunction

endpackage

// File: rtl/midi_baud_counter.sv
// Bit-period counter: counts 0..BIT_TICKS-1 while enabled.
// bit_done pulses on the last tick of each bit; clear wins over enable.
module midi_baud_counter #(
  parameter int BIT_TICKS = 1600
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(BIT_TICKS - 1);

  logic [W-1:0] count;

  assign bit_done = enable && !clear && (count == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= bit_done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: 8N1 UART at BAUD_RATE, LSB first.
// MIDI_TX_RUNNING_STATUS_EN drops repeated channel-status bytes.
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = SYSTEM_CLOCK,
  parameter int BAUD_RATE       = MIDI_BAUD_RATE
) (
  input  logic  clock,
  input  logic  reset_n,
  input  byte_t tx_data,
  input  logic  tx_valid,
  output logic  tx_ready,
  output logic  tx_busy,
  output logic  midi_out
);

  localparam int BIT_TICKS = CLOCK_FREQUENCY / BAUD_RATE;

  tx_state_e  state;
  byte_t      shift;
  logic [2:0] bit_idx;
  logic       accept;
  logic       skip;
  logic       send;
  logic       bit_done;

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && tx_ready;
  assign send     = accept && !skip;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  byte_t last_status;

  assign skip = is_chan_status(tx_data)
             && (tx_data == last_status);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_status <= '0;
    end else if (send) begin
      if (is_chan_status(tx_data)) begin
        last_status <= tx_data;
      end else if (is_syscom(tx_data)) begin
        last_status <= '0;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  midi_baud_counter #(
    .BIT_TICKS(BIT_TICKS)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (send),
    .enable  (state != IDLE),
    .bit_done(bit_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      midi_out <= 1'b1;
      tx_busy  <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (send) begin
            state    <= START;
            midi_out <= 1'b0;
            tx_busy  <= 1'b1;
            shift    <= tx_data;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            midi_out <= shift[0];
            shift    <= shift >> 1;
            bit_idx  <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              midi_out <= 1'b1;
            end else begin
              midi_out <= shift[0];
              shift    <= shift >> 1;
              bit_idx  <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
